// File: rtl/sub_div_seq.sv
// 20-bit unsigned restoring divider: one subtraction per cycle, done 20 cycles after accept (next cycle for /0).
// start is ignored while busy; results are registered and held until the next done pulse.
module sub20 (
  input  logic [19:0] a,
  input  logic [19:0] diff,
  output logic [19:0] d,
  output logic        co
);
  logic [20:0] full;

  assign full = {1'b0, a} - {1'b0, diff};
  assign d    = full[19:0];
  assign co   = ~full[20];
endmodule

module sub_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] dividend,
  input  logic [19:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [19:0] quotient,
  output logic [19:0] remainder,
  output logic        div_by_zero
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_DZ   = 2'd3;

  logic [1:0]  state;
  logic [19:0] rem_r;
  logic [19:0] q_sh;
  logic [19:0] dvs;
  logic [4:0]  cnt;

  logic [19:0] trial;
  logic [19:0] sub_d;
  logic        sub_co;
  logic        qbit;
  logic [19:0] rem_nxt;
  logic [19:0] q_nxt;

  assign trial = {rem_r[18:0], q_sh[19]};

  sub20 u_sub (
    .a    (trial),
    .diff (dvs),
    .d    (sub_d),
    .co   (sub_co)
  );

  // rem_r[19] set means the shifted remainder is >= 2^20, which always exceeds the divisor
  assign qbit    = rem_r[19] | sub_co;
  assign rem_nxt = qbit ? sub_d : trial;
  assign q_nxt   = {q_sh[18:0], qbit};

  assign busy = (state == ST_BUSY);
  assign done = (state == ST_DONE) || (state == ST_DZ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rem_r       <= '0;
      q_sh        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_BUSY: begin
          rem_r <= rem_nxt;
          q_sh  <= q_nxt;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd19) begin
            state       <= ST_DONE;
            quotient    <= q_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          // IDLE, DONE and DZ all accept a new request
          if (start) begin
            dvs   <= divisor;
            rem_r <= '0;
            q_sh  <= dividend;
            cnt   <= '0;
            if (divisor == 20'd0) begin
              state       <= ST_DZ;
              quotient    <= 20'hFFFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_BUSY;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_div_seq.sv
// Randomized and directed checks of sub_div_seq against a plain-arithmetic division model.
module tb_sub_div_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] dividend;
  logic [19:0] divisor;
  logic        busy;
  logic        done;
  logic [19:0] quotient;
  logic [19:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_fail;

  sub_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: presents a request for one rising edge, then scrambles the operands.
  task automatic do_start(input logic [19:0] a, input logic [19:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 20'($urandom);
    divisor  = 20'($urandom);
  endtask

  // Counts falling edges until done is seen (bounded), and how many of them had busy high.
  task automatic run_to_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 20'd0;
    divisor = 20'd0;
    #12;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if (quotient !== 20'd0 || remainder !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_data: got q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    do_start(20'd100, 20'd7);
    run_to_done(lat, bc);
    n_checks++;
    if (lat != 20 || bc != 20) begin
      n_fail++;
      $display("FAIL basic_latency: got lat=%0d busy=%0d expected 20 20", lat, bc);
    end
    n_checks++;
    if (quotient !== 20'd14 || remainder !== 20'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %0d/%0d dz=%b expected 14/2 dz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || quotient !== 20'd14) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: got done=%b q=%0d expected done=0 q=14", done, quotient);
    end
  endtask

  task automatic test_r19();
    int lat, bc;
    do_start(20'hFFFFF, 20'h80001);
    run_to_done(lat, bc);
    n_checks++;
    if (lat != 20 || quotient !== 20'd1 || remainder !== 20'h7FFFE) begin
      n_fail++;
      $display("FAIL r19_path: got lat=%0d %h/%h expected 20 00001/7fffe", lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_start(20'hFFFFF, 20'd1);
    run_to_done(lat, bc);
    n_checks++;
    if (quotient !== 20'hFFFFF || remainder !== 20'd0) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%h expected fffff/00000", quotient, remainder);
    end
    do_start(20'd5, 20'd6);
    n_checks++;
    if (busy !== 1'b1 || quotient !== 20'hFFFFF) begin
      n_fail++;
      $display("FAIL b2b_accept_hold: got busy=%b q=%h expected busy=1 q=fffff", busy, quotient);
    end
    run_to_done(lat, bc);
    n_checks++;
    if (lat != 20 || quotient !== 20'd0 || remainder !== 20'd5) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d %0d/%0d expected 20 0/5", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, bc;
    do_start(20'd5, 20'd0);
    run_to_done(lat, bc);
    n_checks++;
    if (lat != 0 || bc != 0) begin
      n_fail++;
      $display("FAIL dz_latency: got lat=%0d busy=%0d expected 0 0", lat, bc);
    end
    n_checks++;
    if (quotient !== 20'hFFFFF || remainder !== 20'd5 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result: got %h/%0d dz=%b expected fffff/5 dz=1", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_after: got done=%b busy=%b dz=%b expected 0 0 1", done, busy, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    do_start(20'd100, 20'd7);
    repeat (5) @(negedge clk);
    do_start(20'd9, 20'd3);
    run_to_done(lat, bc);
    n_checks++;
    if (lat + 6 != 20 || quotient !== 20'd14 || remainder !== 20'd2) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d %0d/%0d expected 20 14/2", lat + 6, quotient, remainder);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_retrigger: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat, bc, done_seen;
    do_start(20'd100, 20'd7);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 20'd0 || remainder !== 20'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got b/d/z=%b q=%0d r=%0d expected all 0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got %0d active cycles expected 0", done_seen);
    end
    do_start(20'd1000, 20'd10);
    run_to_done(lat, bc);
    n_checks++;
    if (lat != 20 || quotient !== 20'd100 || remainder !== 20'd0) begin
      n_fail++;
      $display("FAIL post_reset_div: got lat=%0d %0d/%0d expected 20 100/0", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc, sel, exp_lat;
    logic [19:0] a, b, exp_q, exp_r;
    logic exp_z;
    for (int i = 0; i < 40; i++) begin
      a = 20'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 20'd0;
      else if (sel < 4) b = 20'($urandom_range(1, 15));
      else b = 20'($urandom_range(1, 20'hFFFFF));
      if (b == 20'd0) begin
        exp_q = 20'hFFFFF; exp_r = a; exp_z = 1'b1; exp_lat = 0;
      end else begin
        exp_q = a / b; exp_r = a % b; exp_z = 1'b0; exp_lat = 20;
      end
      do_start(a, b);
      run_to_done(lat, bc);
      n_checks++;
      if (lat != exp_lat || bc != exp_lat || quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z) begin
        n_fail++;
        $display("FAIL random_%0d: %0d/%0d got lat=%0d busy=%0d q=%0d r=%0d z=%b expected lat=%0d q=%0d r=%0d z=%b",
                 i, a, b, lat, bc, quotient, remainder, div_by_zero, exp_lat, exp_q, exp_r, exp_z);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_r19();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
